ni_resource_port: RTL and testbench
===================================

Name: ni_resource_port

Overview:
- Clocked network-interface bridge between a local core and the router's resource port.
- Core side: synchronous valid/ready flit streams.
- Router side: four-phase bundled-data req/ack channels; the router is unclocked.
- TX path buffers core flits and drives the router's resource input channel. RX path consumes the router's resource output channel and buffers flits for the core.
- Flits are opaque FLIT_W-bit words, passed through unmodified.

Parameters:
- FLIT_W, 35: flit width, matches channel data width.
- TX_DEPTH, 4: TX FIFO entries (power of 2, ≥2).
- RX_DEPTH, 4: RX FIFO entries (power of 2, ≥2).
- SYNC_STAGES, 2: flops on each incoming req/ack (≥2).
- SETUP_CYC, 1: cycles data is held stable before req rises (≥1).

Ports:
- clk  in  1  single clock for the whole block.
- preset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  core offers flit.
- tx_data  in  FLIT_W  core flit.
- tx_ready  out  1  TX FIFO not full.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  FLIT_W  RX FIFO head.
- rx_ready  in  1  core consumes head.
- rtr_in_req  out  1  req to router resource input channel.
- rtr_in_data  out  FLIT_W  data to router resource input channel.
- rtr_in_ack  in  1  ack from router (asynchronous).
- rtr_out_req  in  1  req from router resource output channel (asynchronous).
- rtr_out_data  in  FLIT_W  data from router, valid while rtr_out_req is high.
- rtr_out_ack  out  1  ack to router.
- tx_busy  out  1  TX FSM not in TX_IDLE.
- rx_drop_cnt  out  8  saturating count of protocol errors (see Behaviour).

Behaviour:
- Reset (preset=0, async): both FIFOs empty, FSMs idle, all sync flops 0. Outputs: rtr_in_req=0, rtr_in_data=0, rtr_out_ack=0, tx_ready=0 during reset and 1 after, rx_valid=0, rx_data=0, tx_busy=0, rx_drop_cnt=0.
- Reset mid-handshake aborts the flit in flight. The router side is re-initialised by its own reset.
- rtr_in_ack and rtr_out_req each pass through SYNC_STAGES flops before use. Synced versions are ack_s and req_s.
- TX FIFO:
  - Push when tx_valid && tx_ready.
  - Push and pop in the same cycle are legal when full or empty.
  - tx_ready = !full, registered-count based.
- TX FSM, states TX_IDLE, TX_SETUP, TX_REQ, TX_RTZ:
  - TX_IDLE: if FIFO not empty, register head into rtr_in_data, load setup counter = SETUP_CYC, go to TX_SETUP.
  - TX_SETUP: decrement counter. At 0, set rtr_in_req=1 and go to TX_REQ. rtr_in_data is never changed while req or ack is high.
  - TX_REQ: when ack_s=1, set rtr_in_req=0, pop the FIFO, go to TX_RTZ.
  - TX_RTZ: when ack_s=0, go to TX_IDLE. The next flit may enter TX_SETUP the following cycle.
  - rtr_in_data holds its last value in TX_IDLE.
  - Minimum latency, push to req rise: 2+SETUP_CYC cycles when the FIFO was empty.
- RX FSM, states RX_IDLE, RX_ACK:
  - RX_IDLE: if req_s=1 and RX FIFO not full, push rtr_out_data, set rtr_out_ack=1, go to RX_ACK.
  - RX_IDLE with RX FIFO full: hold ack low; this is backpressure and no data is lost.
  - RX_ACK: when req_s=0, set rtr_out_ack=0 and go to RX_IDLE.
  - Data is sampled on the cycle req_s is first seen high. Bundled-data convention: data is stable before req and held until ack.
- RX FIFO: rx_valid = !empty; rx_data = head, registered. Simultaneous push and pop are allowed.
- rx_drop_cnt increments (saturating at 255) when req_s falls while in RX_IDLE without having been acked. This indicates a protocol violation by the router.
- A one-cycle req glitch shorter than the synchronizer is not required to be seen.
- No combinational path from any router-side input to any output.

Test Plan:
- Single TX flit: push 35'h6_07C0_000B; the router model acks 3 cycles after req and drops ack 2 cycles after req falls. Required:
  - rtr_in_data = 35'h6_07C0_000B at least SETUP_CYC cycles before rtr_in_req rises.
  - req falls SYNC_STAGES+1 cycles after the ack edge.
  - tx_busy returns to 0.
  - FIFO is empty.
- TX full: push 5 flits 0x1..0x5 with ack held low. Required:
  - tx_ready=0 after the 4th push; the 5th flit is stalled.
  - After acks resume, the router sees 0x1..0x5 in order, with exactly one req pulse each.
- Single RX flit: router drives data 35'h6_07C0_0000, then req=1. Required:
  - rtr_out_ack rises SYNC_STAGES+1 cycles later.
  - rx_valid=1 with rx_data=35'h6_07C0_0000.
  - ack drops after req drops.
- RX backpressure: rx_ready=0, router sends 5 flits. Required:
  - 4 flits acked; the 5th req is held with ack=0.
  - After rx_ready=1, all 5 delivered in order and rx_drop_cnt=0.
- Concurrent TX/RX: both directions stream 8 flits simultaneously. Required: no loss, no reorder, no interaction between paths.
- Reset mid-operation: assert preset=0 while in TX_REQ and RX_ACK. Required:
  - All outputs go to their reset values asynchronously, before the next clock edge.
  - FIFOs empty.
  - After release, a fresh flit transfers normally.

Source files
------------

// File: rtl/ni_resource_port.sv
// Generic flit FIFO: DEPTH-entry circular buffer with an occupancy counter.
// Latency: a pushed word is at head_dat on the cycle after the push; head_dat is driven from flops.
// Backpressure: full/empty come from the registered count; a push is accepted when full only if a pop happens in the same cycle.
module ni_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         preset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    do_pop   = pop_vld && !empty;
    do_push  = push_vld && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// Bridge between core valid/ready flit streams and the router's four-phase bundled-data resource port.
// Latency: TX push to req rise 2+SETUP_CYC cycles; RX req to ack rise SYNC_STAGES+1 cycles.
// Backpressure: tx_ready drops when the TX FIFO is full; a full RX FIFO holds rtr_out_ack low so the router waits.
module ni_resource_port #(
  parameter int FLIT_W      = 35,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC   = 1
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              tx_valid,
  input  logic [FLIT_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [FLIT_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic              rtr_in_req,
  output logic [FLIT_W-1:0] rtr_in_data,
  input  logic              rtr_in_ack,
  input  logic              rtr_out_req,
  input  logic [FLIT_W-1:0] rtr_out_data,
  output logic              rtr_out_ack,
  output logic              tx_busy,
  output logic [7:0]        rx_drop_cnt
);
  localparam int CNT_W = $clog2(SETUP_CYC + 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_REQ, TX_RTZ} tx_state_e;
  typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  rx_state_e              rx_state_q, rx_state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic                   ack_s, req_s;
  logic                   req_prev_q, req_prev_d;
  logic                   rst_done_q;
  logic                   tx_full, tx_empty, tx_pop;
  logic [FLIT_W-1:0]      tx_head;
  logic                   in_req_q, in_req_d;
  logic [FLIT_W-1:0]      in_data_q, in_data_d;
  logic [CNT_W-1:0]       setup_cnt_q, setup_cnt_d;
  logic                   rx_full, rx_empty, rx_push;
  logic                   out_ack_q, out_ack_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;

  assign ack_s       = ack_sync_q[SYNC_STAGES-1];
  assign req_s       = req_sync_q[SYNC_STAGES-1];
  assign tx_ready    = rst_done_q && !tx_full;
  assign rx_valid    = !rx_empty;
  assign rtr_in_req  = in_req_q;
  assign rtr_in_data = in_data_q;
  assign rtr_out_ack = out_ack_q;
  assign tx_busy     = (tx_state_q != TX_IDLE);
  assign rx_drop_cnt = drop_cnt_q;

  ni_fifo #(.W(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .preset(preset),
    .push_vld(tx_valid && tx_ready), .push_dat(tx_data),
    .pop_vld(tx_pop), .head_dat(tx_head),
    .full(tx_full), .empty(tx_empty)
  );

  ni_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .preset(preset),
    .push_vld(rx_push), .push_dat(rtr_out_data),
    .pop_vld(rx_valid && rx_ready), .head_dat(rx_data),
    .full(rx_full), .empty(rx_empty)
  );

  // Shift the asynchronous router handshakes through the synchronizer chains.
  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], rtr_in_ack};
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], rtr_out_req};
    req_prev_d = req_s;
  end

  // Synchronizers, req edge history and the post-reset ready qualifier.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      ack_sync_q <= '0;
      req_sync_q <= '0;
      req_prev_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      ack_sync_q <= ack_sync_d;
      req_sync_q <= req_sync_d;
      req_prev_q <= req_prev_d;
      rst_done_q <= 1'b1;
    end
  end

  // TX next state: launch a flit, hold data for the setup time, then run the four-phase cycle.
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      TX_IDLE:  if (!tx_empty) tx_state_d = TX_SETUP;
      TX_SETUP: if (setup_cnt_q == '0) tx_state_d = TX_REQ;
      TX_REQ:   if (ack_s) tx_state_d = TX_RTZ;
      TX_RTZ:   if (!ack_s) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // TX outputs: data is loaded only in idle, so it never moves while req or ack is high.
  always_comb begin
    in_req_d    = in_req_q;
    in_data_d   = in_data_q;
    setup_cnt_d = setup_cnt_q;
    tx_pop      = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          in_data_d   = tx_head;
          setup_cnt_d = CNT_W'(SETUP_CYC);
        end
      end
      TX_SETUP: begin
        if (setup_cnt_q == '0) in_req_d = 1'b1;
        else setup_cnt_d = setup_cnt_q - CNT_W'(1);
      end
      TX_REQ: begin
        if (ack_s) begin
          in_req_d = 1'b0;
          tx_pop   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // TX state and registered router-facing outputs.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      tx_state_q  <= TX_IDLE;
      in_req_q    <= 1'b0;
      in_data_q   <= '0;
      setup_cnt_q <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      in_req_q    <= in_req_d;
      in_data_q   <= in_data_d;
      setup_cnt_q <= setup_cnt_d;
    end
  end

  // RX next state: accept only when there is room, then wait for the router to return req to zero.
  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RX_IDLE: if (req_s && !rx_full) rx_state_d = RX_ACK;
      RX_ACK:  if (!req_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX outputs: sample data on first sight of req_s; a req withdrawn without ack counts as a drop.
  always_comb begin
    out_ack_d  = out_ack_q;
    rx_push    = 1'b0;
    drop_cnt_d = drop_cnt_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (req_s && !rx_full) begin
          rx_push   = 1'b1;
          out_ack_d = 1'b1;
        end else if (req_prev_q && !req_s && (drop_cnt_q != 8'hFF)) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      RX_ACK: if (!req_s) out_ack_d = 1'b0;
      default: ;
    endcase
  end

  // RX state, ack output and protocol-error counter.
  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      rx_state_q <= RX_IDLE;
      out_ack_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      out_ack_q  <= out_ack_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_ni_resource_port.sv
// Self-checking bench for ni_resource_port: table of single transfers, hand-written corner cases,
// and randomized concurrent streams compared against order-preserving queue models.
// All stimulus and sampling happen on the falling clock edge.
module tb_ni_resource_port;
  localparam int FLIT_W      = 35;
  localparam int SYNC_STAGES = 2;
  localparam int SETUP_CYC   = 1;
  localparam int TX_RISE     = 2 + SETUP_CYC;
  localparam int HS_LAT      = SYNC_STAGES + 1;

  logic              clk, preset;
  logic              tx_valid, tx_ready, rx_valid, rx_ready;
  logic [FLIT_W-1:0] tx_data, rx_data, rtr_in_data, rtr_out_data;
  logic              rtr_in_req, rtr_in_ack, rtr_out_req, rtr_out_ack, tx_busy;
  logic [7:0]        rx_drop_cnt;

  int checks, errors, exp_drops;
  logic [FLIT_W-1:0] rtr_seen[$];
  logic [FLIT_W-1:0] rx_got[$];

  typedef struct {
    bit                is_rx;
    logic [FLIT_W-1:0] dat;
    int                lat_rise;
    int                lat_fall;
  } vec_t;
  vec_t vecs[6];
  vec_t post_vecs[2];

  ni_resource_port #(
    .FLIT_W(FLIT_W), .TX_DEPTH(4), .RX_DEPTH(4),
    .SYNC_STAGES(SYNC_STAGES), .SETUP_CYC(SETUP_CYC)
  ) dut (
    .clk(clk), .preset(preset),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .rtr_in_req(rtr_in_req), .rtr_in_data(rtr_in_data), .rtr_in_ack(rtr_in_ack),
    .rtr_out_req(rtr_out_req), .rtr_out_data(rtr_out_data), .rtr_out_ack(rtr_out_ack),
    .tx_busy(tx_busy), .rx_drop_cnt(rx_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [FLIT_W-1:0] rand_flit();
    return FLIT_W'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required handshake within bound", nm);
  endtask

  task automatic chk_q(input string nm, input logic [FLIT_W-1:0] got[$], input logic [FLIT_W-1:0] exp[$]);
    chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_req"},   64'(rtr_in_req),  64'(0));
    chk({nm, "_in_data"},  64'(rtr_in_data), 64'(0));
    chk({nm, "_out_ack"},  64'(rtr_out_ack), 64'(0));
    chk({nm, "_tx_ready"}, 64'(tx_ready),    64'(0));
    chk({nm, "_rx_valid"}, 64'(rx_valid),    64'(0));
    chk({nm, "_rx_data"},  64'(rx_data),     64'(0));
    chk({nm, "_tx_busy"},  64'(tx_busy),     64'(0));
    chk({nm, "_drops"},    64'(rx_drop_cnt), 64'(0));
  endtask

  // One isolated transfer in either direction, with latency measurement.
  task automatic apply_vec(input vec_t v, input string nm);
    int n;
    logic [FLIT_W-1:0] prev;
    if (!v.is_rx) begin
      tx_data = v.dat; tx_valid = 1'b1;
      @(negedge clk); tx_valid = 1'b0;
      n = 0; prev = rtr_in_data;
      while (!rtr_in_req && n < 40) begin prev = rtr_in_data; @(negedge clk); n++; end
      chk({nm, "_req_lat"}, 64'(n), 64'(v.lat_rise));
      chk({nm, "_setup_data"}, 64'(prev), 64'(v.dat));
      repeat (3) @(negedge clk);
      chk({nm, "_data_held"}, 64'(rtr_in_data), 64'(v.dat));
      rtr_in_ack = 1'b1;
      n = 0;
      while (rtr_in_req && n < 40) begin @(negedge clk); n++; end
      chk({nm, "_req_fall"}, 64'(n), 64'(v.lat_fall));
      repeat (2) @(negedge clk);
      rtr_in_ack = 1'b0;
      n = 0;
      while (tx_busy && n < 40) begin @(negedge clk); n++; end
      @(negedge clk);
      chk({nm, "_busy_idle"}, 64'(tx_busy), 64'(0));
      chk({nm, "_no_req"}, 64'(rtr_in_req), 64'(0));
    end else begin
      rtr_out_data = v.dat;
      @(negedge clk); rtr_out_req = 1'b1;
      n = 0;
      while (!rtr_out_ack && n < 40) begin @(negedge clk); n++; end
      chk({nm, "_ack_lat"}, 64'(n), 64'(v.lat_rise));
      chk({nm, "_rx_valid"}, 64'(rx_valid), 64'(1));
      chk({nm, "_rx_data"}, 64'(rx_data), 64'(v.dat));
      repeat (2) @(negedge clk);
      chk({nm, "_ack_hold"}, 64'(rtr_out_ack), 64'(1));
      rtr_out_req = 1'b0; rtr_out_data = rand_flit();
      n = 0;
      while (rtr_out_ack && n < 40) begin @(negedge clk); n++; end
      chk({nm, "_ack_fall"}, 64'(n), 64'(v.lat_fall));
      rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      chk({nm, "_rx_empty"}, 64'(rx_valid), 64'(0));
    end
  endtask

  // Core side: offer each flit until accepted, with random idle gaps.
  task automatic core_tx_send(input logic [FLIT_W-1:0] q[$]);
    bit ok;
    int c;
    foreach (q[i]) begin
      tx_data = q[i]; tx_valid = 1'b1; ok = 1'b0; c = 0;
      while (!ok && c < 3000) begin ok = tx_ready; @(negedge clk); c++; end
      if (!ok) begin tx_valid = 1'b0; timeout_fail("core_tx_send"); return; end
      if ($urandom_range(0, 2) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
  endtask

  // Router side of the TX channel: ack each req after a random delay and log the data.
  task automatic router_tx_collect(input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      c = 0;
      while (!rtr_in_req && c < 3000) begin @(negedge clk); c++; end
      if (!rtr_in_req) begin timeout_fail("router_tx_req"); return; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rtr_seen.push_back(rtr_in_data);
      rtr_in_ack = 1'b1;
      c = 0;
      while (rtr_in_req && c < 100) begin @(negedge clk); c++; end
      if (rtr_in_req) begin rtr_in_ack = 1'b0; timeout_fail("router_tx_rtz"); return; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rtr_in_ack = 1'b0;
    end
  endtask

  // Router side of the RX channel: bundled data set up one cycle before req.
  task automatic router_rx_send(input logic [FLIT_W-1:0] q[$]);
    int c;
    foreach (q[i]) begin
      rtr_out_data = q[i];
      @(negedge clk); rtr_out_req = 1'b1;
      c = 0;
      while (!rtr_out_ack && c < 3000) begin @(negedge clk); c++; end
      if (!rtr_out_ack) begin rtr_out_req = 1'b0; timeout_fail("router_rx_ack"); return; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rtr_out_req = 1'b0; rtr_out_data = rand_flit();
      c = 0;
      while (rtr_out_ack && c < 100) begin @(negedge clk); c++; end
      if (rtr_out_ack) begin timeout_fail("router_rx_rtz"); return; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // Core side of RX: random rx_ready, log every flit popped.
  task automatic core_rx_collect(input int n);
    int c;
    c = 0;
    while (rx_got.size() < n && c < 3000) begin
      rx_ready = ($urandom_range(0, 3) != 0);
      if (rx_ready && rx_valid) rx_got.push_back(rx_data);
      @(negedge clk); c++;
    end
    rx_ready = 1'b0;
    if (rx_got.size() < n) timeout_fail("core_rx_collect");
  endtask

  initial begin
    logic [FLIT_W-1:0] q_a[$];
    logic [FLIT_W-1:0] q_b[$];
    logic [FLIT_W-1:0] f5;
    int c, n;

    checks = 0; errors = 0; exp_drops = 0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    rtr_in_ack = 1'b0; rtr_out_req = 1'b0; rtr_out_data = '0;
    preset = 1'b1;
    #2 preset = 1'b0;
    #1 check_reset("por");
    repeat (3) @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    chk("tx_ready_after_rst", 64'(tx_ready), 64'(1));

    vecs[0] = '{1'b0, 35'h6_07C0_000B, TX_RISE, HS_LAT};
    vecs[1] = '{1'b1, 35'h6_07C0_0000, HS_LAT, HS_LAT};
    vecs[2] = '{1'b0, 35'h7_FFFF_FFFF, TX_RISE, HS_LAT};
    vecs[3] = '{1'b1, 35'h5_5555_5555, HS_LAT, HS_LAT};
    vecs[4] = '{1'b0, 35'h0_0000_0000, TX_RISE, HS_LAT};
    vecs[5] = '{1'b1, 35'h2_AAAA_AAAA, HS_LAT, HS_LAT};
    foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // TX full: no acks, four pushes fill the FIFO, the fifth stalls.
    for (int i = 1; i <= 4; i++) begin
      tx_data = FLIT_W'(i); tx_valid = 1'b1;
      chk($sformatf("txfull_ready%0d", i), 64'(tx_ready), 64'(1));
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("txfull_ready_after4", 64'(tx_ready), 64'(0));
    tx_data = FLIT_W'(5); tx_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("txfull_stalled", 64'(tx_ready), 64'(0));
    chk("txfull_req_first", 64'(rtr_in_req), 64'(1));
    chk("txfull_data_first", 64'(rtr_in_data), 64'(1));
    q_a.delete(); q_a.push_back(FLIT_W'(5));
    rtr_seen.delete();
    fork
      core_tx_send(q_a);
      router_tx_collect(5);
    join
    q_b.delete();
    for (int i = 1; i <= 5; i++) q_b.push_back(FLIT_W'(i));
    chk_q("txfull_order", rtr_seen, q_b);
    repeat (8) @(negedge clk);
    chk("txfull_no_extra_req", 64'(rtr_in_req), 64'(0));
    chk("txfull_idle", 64'(tx_busy), 64'(0));

    // RX backpressure: four accepted with rx_ready low, the fifth req waits with ack low.
    q_a.delete();
    for (int i = 0; i < 4; i++) q_a.push_back(rand_flit());
    f5 = rand_flit();
    router_rx_send(q_a);
    rtr_out_data = f5;
    @(negedge clk); rtr_out_req = 1'b1;
    repeat (8) @(negedge clk);
    chk("rxbp_ack_held_low", 64'(rtr_out_ack), 64'(0));
    chk("rxbp_head", 64'(rx_data), 64'(q_a[0]));
    rx_got.delete();
    fork
      core_rx_collect(5);
      begin
        c = 0;
        while (!rtr_out_ack && c < 500) begin @(negedge clk); c++; end
        if (!rtr_out_ack) timeout_fail("rxbp_fifth_ack");
        rtr_out_req = 1'b0;
        c = 0;
        while (rtr_out_ack && c < 100) begin @(negedge clk); c++; end
      end
    join
    q_b = q_a; q_b.push_back(f5);
    chk_q("rxbp_order", rx_got, q_b);
    chk("rxbp_drops", 64'(rx_drop_cnt), 64'(exp_drops));

    // Protocol error: req withdrawn while the full FIFO never acked it.
    q_a.delete();
    for (int i = 0; i < 4; i++) q_a.push_back(rand_flit());
    router_rx_send(q_a);
    rtr_out_data = rand_flit();
    @(negedge clk); rtr_out_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("drop_no_ack", 64'(rtr_out_ack), 64'(0));
    rtr_out_req = 1'b0;
    exp_drops++;
    repeat (5) @(negedge clk);
    chk("drop_count", 64'(rx_drop_cnt), 64'(exp_drops));
    rx_got.delete();
    core_rx_collect(4);
    chk_q("drop_kept", rx_got, q_a);

    // Concurrent randomized streams in both directions.
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 8 : $urandom_range(4, 12);
      q_a.delete(); q_b.delete();
      for (int i = 0; i < n; i++) begin
        q_a.push_back(rand_flit());
        q_b.push_back(rand_flit());
      end
      rtr_seen.delete(); rx_got.delete();
      fork
        core_tx_send(q_a);
        router_tx_collect(n);
        router_rx_send(q_b);
        core_rx_collect(n);
      join
      chk_q($sformatf("conc%0d_tx", r), rtr_seen, q_a);
      chk_q($sformatf("conc%0d_rx", r), rx_got, q_b);
      chk($sformatf("conc%0d_drops", r), 64'(rx_drop_cnt), 64'(exp_drops));
    end

    // Reset while TX sits in req-high and RX in ack-high.
    tx_data = rand_flit(); tx_valid = 1'b1;
    @(negedge clk); tx_data = rand_flit();
    @(negedge clk); tx_valid = 1'b0;
    rtr_out_data = rand_flit();
    @(negedge clk); rtr_out_req = 1'b1;
    c = 0;
    while (!(rtr_in_req && rtr_out_ack) && c < 50) begin @(negedge clk); c++; end
    chk("mid_handshakes_open", 64'(rtr_in_req && rtr_out_ack), 64'(1));
    #2 preset = 1'b0;
    #1 check_reset("mid_rst");
    rtr_in_ack = 1'b0; rtr_out_req = 1'b0;
    @(negedge clk); @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    chk("mid_tx_ready", 64'(tx_ready), 64'(1));
    chk("mid_rx_empty", 64'(rx_valid), 64'(0));
    repeat (4) @(negedge clk);
    chk("mid_tx_fifo_empty", 64'(tx_busy), 64'(0));
    chk("mid_no_stale_req", 64'(rtr_in_req), 64'(0));
    post_vecs[0] = '{1'b0, 35'h1_2345_6789, TX_RISE, HS_LAT};
    post_vecs[1] = '{1'b1, 35'h4_0F0F_F0F0, HS_LAT, HS_LAT};
    foreach (post_vecs[i]) apply_vec(post_vecs[i], $sformatf("post%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
